// File: rtl/npu_sigmoid_unit.sv
// Activation stage: rescale a Q32.16 accumulator to saturated Q8.8, then apply a
// three-stage shift-add piecewise-linear sigmoid behind a valid/ready handshake.
module npu_sigmoid_unit #(
   parameter int unsigned ACC_SHIFT = 8,
   parameter int unsigned SAT_CNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 npu_rst_n,
   input  logic                 npu_sig_in_valid,
   output logic                 npu_sig_in_ready,
   input  logic [47:0]          npu_sig_acc_in,
   input  logic                 npu_sig_bypass,
   output logic                 npu_sig_out_valid,
   input  logic                 npu_sig_out_ready,
   output logic [15:0]          npu_sig_data_out,
   output logic [SAT_CNT_W-1:0] npu_sig_sat_cnt,
   input  logic                 npu_sig_sat_cnt_clr
);

   logic                 adv;
   logic                 in_xfer;

   logic signed [47:0]   acc_shr;
   logic                 s1_sat_d;
   logic [15:0]          s1_x_d;
   logic [14:0]          s1_mag;
   logic [14:0]          s1_a_d;

   logic                 s1_vld_q, s1_neg_q, s1_byp_q;
   logic [15:0]          s1_x_q;
   logic [14:0]          s1_a_q;

   logic [8:0]           s2_y_d;
   logic                 s2_vld_q, s2_neg_q, s2_byp_q;
   logic [15:0]          s2_x_q;
   logic [8:0]           s2_y_q;

   logic [15:0]          s3_data_d;
   logic                 s3_vld_q;
   logic [15:0]          s3_data_q;

   logic [SAT_CNT_W-1:0] sat_cnt_d, sat_cnt_q;

   // The whole pipeline moves as one; a stalled output freezes every stage.
   assign adv     = !s3_vld_q || npu_sig_out_ready;
   assign in_xfer = npu_sig_in_valid && adv;

   assign acc_shr = $signed(npu_sig_acc_in) >>> ACC_SHIFT;

   always_comb begin
      s1_sat_d = 1'b0;
      s1_x_d   = acc_shr[15:0];
      if (acc_shr > 48'sd32767) begin
         s1_x_d   = 16'h7FFF;
         s1_sat_d = 1'b1;
      end else if (acc_shr < -48'sd32768) begin
         s1_x_d   = 16'h8000;
         s1_sat_d = 1'b1;
      end
      s1_mag = s1_x_d[15] ? (~s1_x_d[14:0] + 15'd1) : s1_x_d[14:0];
      // -32768 has no positive Q8.8 counterpart; fold it onto the largest magnitude.
      s1_a_d = (s1_x_d == 16'h8000) ? 15'h7FFF : s1_mag;
   end

   always_comb begin
      if (s1_a_q >= 15'd1280) begin
         s2_y_d = 9'd256;
      end else if (s1_a_q >= 15'd608) begin
         s2_y_d = 9'(s1_a_q >> 5) + 9'd216;
      end else if (s1_a_q >= 15'd256) begin
         s2_y_d = 9'(s1_a_q >> 3) + 9'd160;
      end else begin
         s2_y_d = 9'(s1_a_q >> 2) + 9'd128;
      end
   end

   always_comb begin
      if (s2_byp_q) begin
         s3_data_d = s2_x_q;
      end else if (s2_neg_q) begin
         s3_data_d = 16'd256 - {7'd0, s2_y_q};
      end else begin
         s3_data_d = {7'd0, s2_y_q};
      end
   end

   always_ff @(posedge CLK or negedge npu_rst_n) begin
      if (!npu_rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_neg_q  <= 1'b0;
         s1_byp_q  <= 1'b0;
         s1_x_q    <= '0;
         s1_a_q    <= '0;
         s2_vld_q  <= 1'b0;
         s2_neg_q  <= 1'b0;
         s2_byp_q  <= 1'b0;
         s2_x_q    <= '0;
         s2_y_q    <= '0;
         s3_vld_q  <= 1'b0;
         s3_data_q <= '0;
      end else if (adv) begin
         s1_vld_q  <= in_xfer;
         s1_neg_q  <= s1_x_d[15];
         s1_byp_q  <= npu_sig_bypass;
         s1_x_q    <= s1_x_d;
         s1_a_q    <= s1_a_d;
         s2_vld_q  <= s1_vld_q;
         s2_neg_q  <= s1_neg_q;
         s2_byp_q  <= s1_byp_q;
         s2_x_q    <= s1_x_q;
         s2_y_q    <= s2_y_d;
         s3_vld_q  <= s2_vld_q;
         s3_data_q <= s3_data_d;
      end
   end

   // Counted at acceptance so downstream stalls never hide a saturation event.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (npu_sig_sat_cnt_clr) begin
         sat_cnt_d = '0;
      end else if (in_xfer && s1_sat_d && (sat_cnt_q != '1)) begin
         sat_cnt_d = sat_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge npu_rst_n) begin
      if (!npu_rst_n) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign npu_sig_in_ready  = adv;
   assign npu_sig_out_valid = s3_vld_q;
   assign npu_sig_data_out  = s3_data_q;
   assign npu_sig_sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_npu_sigmoid_unit.sv
// Self-checking bench for npu_sigmoid_unit: arithmetic reference model plus
// directed vectors with hand-computed Q8.8 results.
module tb_npu_sigmoid_unit;

   localparam int unsigned SHIFT   = 8;
   localparam int unsigned SATW    = 4;
   localparam int          SAT_MAX = (1 << SATW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [47:0]     acc_in;
   logic            byp;
   logic            out_valid;
   logic            out_ready;
   logic [15:0]     data_out;
   logic [SATW-1:0] sat_cnt;
   logic            clr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc_cnt = 0;
   int m_cnt  = 0;
   bit prev_stall = 0;
   logic [15:0] prev_data = '0;
   bit rand_done = 0;

   logic [15:0] exp_q [$];
   logic [15:0] out_log [$];
   int          out_cyc [$];

   int bnd [12] = '{255, 256, 607, 608, 1279, 1280, 32767, 32768, 0, 1, 2047, 32769};

   npu_sigmoid_unit #(
      .ACC_SHIFT(SHIFT),
      .SAT_CNT_W(SATW)
   ) dut (
      .CLK                 (clk),
      .npu_rst_n           (rst_n),
      .npu_sig_in_valid    (in_valid),
      .npu_sig_in_ready    (in_ready),
      .npu_sig_acc_in      (acc_in),
      .npu_sig_bypass      (byp),
      .npu_sig_out_valid   (out_valid),
      .npu_sig_out_ready   (out_ready),
      .npu_sig_data_out    (data_out),
      .npu_sig_sat_cnt     (sat_cnt),
      .npu_sig_sat_cnt_clr (clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: sigmoid evaluated directly on the rescaled accumulator value.
   function automatic logic [15:0] model(input logic [47:0] acc, input bit b, output bit sat);
      longint t, x, a, y;
      t   = longint'($signed(acc)) >>> SHIFT;
      x   = t;
      sat = 0;
      if (t > 32767) begin x = 32767; sat = 1; end
      else if (t < -32768) begin x = -32768; sat = 1; end
      a = (x < 0) ? -x : x;
      if (a > 32767) a = 32767;
      if (a >= 1280)     y = 256;
      else if (a >= 608) y = a / 32 + 216;
      else if (a >= 256) y = a / 8 + 160;
      else               y = a / 4 + 128;
      if (b)          return 16'(x);
      else if (x < 0) return 16'(256 - y);
      else            return 16'(y);
   endfunction

   always @(negedge clk) begin
      bit s;
      logic [15:0] e;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_sat_cnt", sat_cnt, 0);
         exp_q.delete();
         m_cnt = 0;
         prev_stall = 0;
      end else begin
         chk("sat_cnt", sat_cnt, m_cnt);
         chk("in_ready", in_ready, (!out_valid || out_ready));
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", data_out, prev_data);
         end
         if (out_valid && out_ready) begin
            out_log.push_back(data_out);
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got 0x%0h with no word outstanding", data_out);
            end else begin
               chk("data_out", data_out, exp_q.pop_front());
            end
         end
         s = 0;
         if (in_valid && in_ready) begin
            e = model(acc_in, byp, s);
            exp_q.push_back(e);
            acc_cnt++;
         end
         if (clr) m_cnt = 0;
         else if (s && m_cnt < SAT_MAX) m_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = data_out;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the transfer edge.
   task automatic send(input logic [47:0] acc, input bit b);
      int w = 0;
      in_valid = 1'b1;
      acc_in   = acc;
      byp      = b;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", w);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic lat(input logic [47:0] acc, input bit b, input logic [15:0] exp);
      in_valid = 1'b1;
      acc_in   = acc;
      byp      = b;
      @(negedge clk); chk("lat_in_ready", in_ready, 1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); chk("lat_c1_valid", out_valid, 0);
      @(negedge clk); chk("lat_c2_valid", out_valid, 0);
      @(negedge clk); chk("lat_c3_valid", out_valid, 1); chk("lat_c3_data", data_out, exp);
      @(negedge clk); chk("lat_c4_valid", out_valid, 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [47:0] rand_acc();
      longint v;
      logic [63:0] r;
      case ($urandom_range(0, 3))
         0: v = longint'($urandom_range(0, 32'hC0000)) - 64'sh60000;
         1: v = longint'($urandom_range(0, 32'h1000000)) - 64'sh800000;
         2: begin r = {$urandom, $urandom}; v = longint'(r); end
         default: begin
            v = longint'(bnd[$urandom_range(0, 11)]);
            if ($urandom_range(0, 1) == 1) v = -v;
            v = (v <<< SHIFT) + longint'($urandom_range(0, 255));
         end
      endcase
      return v[47:0];
   endfunction

   logic [47:0] bp_acc [5] = '{48'h0, 48'h18000, 48'hFFFF_FFFE_8000, 48'h30000, 48'h60000};
   logic [15:0] bp_exp [5] = '{16'h0080, 16'h00D0, 16'h0030, 16'h00F0, 16'h0100};

   initial begin
      int base;
      rst_n = 1'b0; in_valid = 1'b0; acc_in = '0; byp = 1'b0; out_ready = 1'b1; clr = 1'b0;
      #3;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_data_out", data_out, 0);
      chk("reset_sat_cnt", sat_cnt, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      lat(48'h0, 1'b0, 16'h0080);

      out_log.delete(); out_cyc.delete();
      for (int i = 1; i < 5; i++) send(bp_acc[i], 1'b0);
      drain();
      chk("stream_count", out_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("stream_val", out_log[i], bp_exp[i+1]);
      for (int i = 1; i < 4; i++) chk("stream_gap", out_cyc[i] - out_cyc[i-1], 1);

      out_log.delete();
      send(48'h7FFF_FFFF_FFFF, 1'b1);
      send(48'h8000_0000_0000, 1'b1);
      send(48'h8000_0000_0000, 1'b0);
      drain();
      chk("sat_out_count", out_log.size(), 3);
      chk("sat_pos_bypass", out_log[0], 16'h7FFF);
      chk("sat_neg_bypass", out_log[1], 16'h8000);
      chk("sat_neg_sigmoid", out_log[2], 16'h0000);
      chk("sat_cnt_three", sat_cnt, 3);
      for (int i = 0; i < 14; i++) send(48'h7FFF_FFFF_FFFF, i[0]);
      drain();
      chk("sat_cnt_stick", sat_cnt, SAT_MAX);
      clr = 1'b1;
      send(48'h8000_0000_0000, 1'b0);
      clr = 1'b0;
      @(negedge clk); chk("sat_clr_priority", sat_cnt, 0);
      @(posedge clk); #1;
      drain();

      out_log.delete();
      out_ready = 1'b0;
      base = acc_cnt;
      fork
         begin
            for (int i = 0; i < 5; i++) send(bp_acc[i], 1'b0);
         end
         begin
            repeat (6) @(negedge clk);
            chk("bp_accepted", acc_cnt - base, 3);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_no_output", out_log.size(), 0);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_out_count", out_log.size(), 5);
      for (int i = 0; i < 5; i++) chk("bp_order", out_log[i], bp_exp[i]);

      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               send(rand_acc(), $urandom_range(0, 3) == 0);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
               clr       = ($urandom_range(0, 63) == 0);
            end
         end
      join
      out_ready = 1'b1;
      clr = 1'b0;
      drain();

      send(48'h7FFF_FFFF_FFFF, 1'b0);
      send(48'h8000_0000_0000, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_sat_cnt", sat_cnt, (m_cnt > 0) ? m_cnt : 32'hFFFF_FFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_sat_cnt", sat_cnt, 0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      lat(48'h18000, 1'b0, 16'h00D0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
